// File: rtl/rvs192_local_bp.sv
// Local-history branch predictor: per-PC history table indexing a shared 2-bit
// counter PHT, plus a direct-mapped BTB and saturating branch/mispredict counters.
module rvs192_local_bp #(
  parameter int unsigned PC_LENGTH            = 32,
  parameter int unsigned LOCAL_HISTORY_LENGTH = 4,
  parameter int unsigned LHT_ENTRIES          = 64,
  parameter int unsigned BTB_ENTRIES          = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [PC_LENGTH-1:0]              fetch_pc,
  output logic [LOCAL_HISTORY_LENGTH+2:0]   br_check,
  output logic [PC_LENGTH-1:0]              pred_pc,
  input  logic [LOCAL_HISTORY_LENGTH+4:0]   br_update,
  input  logic [PC_LENGTH-1:0]              update_pc,
  input  logic [PC_LENGTH-1:0]              update_target,
  output logic [31:0]                       branch_cnt,
  output logic [31:0]                       mispredict_cnt
);

  localparam int unsigned L      = LOCAL_HISTORY_LENGTH;
  localparam int unsigned PHT_N  = 1 << L;
  localparam int unsigned LHT_IW = $clog2(LHT_ENTRIES);
  localparam int unsigned BTB_IW = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W  = PC_LENGTH - BTB_IW - 2;

  logic [L-1:0]           r_lht     [LHT_ENTRIES];
  logic [1:0]             r_pht     [PHT_N];
  logic [BTB_ENTRIES-1:0] r_btb_vld;
  logic [TAG_W-1:0]       r_btb_tag [BTB_ENTRIES];
  logic [PC_LENGTH-1:0]   r_btb_tgt [BTB_ENTRIES];
  logic [31:0]            r_branch_cnt;
  logic [31:0]            r_mispredict_cnt;
  logic                   r_upd_en;

  logic [LHT_IW-1:0]    w_f_lht_idx;
  logic [BTB_IW-1:0]    w_f_btb_idx;
  logic [TAG_W-1:0]     w_f_tag;
  logic [L-1:0]         w_lbhr;
  logic [1:0]           w_predict;
  logic                 w_btb_hit;
  logic                 w_take;

  logic [1:0]           w_pred_upd;
  logic [L-1:0]         w_lbhr_old;
  logic                 w_update;
  logic                 w_wrong;
  logic                 w_actual;
  logic                 w_upd;
  logic [LHT_IW-1:0]    w_u_lht_idx;
  logic [BTB_IW-1:0]    w_u_btb_idx;
  logic [TAG_W-1:0]     w_u_tag;
  logic [1:0]           w_pht_new;

  // Lookup path
  always_comb begin
    w_f_lht_idx = fetch_pc[LHT_IW+1:2];
    w_f_btb_idx = fetch_pc[BTB_IW+1:2];
    w_f_tag     = fetch_pc[PC_LENGTH-1:BTB_IW+2];
    w_lbhr      = r_lht[w_f_lht_idx];
    w_predict   = r_pht[w_lbhr];
    w_btb_hit   = r_btb_vld[w_f_btb_idx] && (r_btb_tag[w_f_btb_idx] == w_f_tag);
    w_take      = w_btb_hit && w_predict[1];
    pred_pc     = w_take ? r_btb_tgt[w_f_btb_idx] : fetch_pc + PC_LENGTH'(4);
    br_check    = {w_predict, w_lbhr, w_take};
  end

  // Training path decode
  always_comb begin
    {w_pred_upd, w_lbhr_old, w_update, w_wrong, w_actual} = br_update;
    w_upd       = w_update && r_upd_en;
    w_u_lht_idx = update_pc[LHT_IW+1:2];
    w_u_btb_idx = update_pc[BTB_IW+1:2];
    w_u_tag     = update_pc[PC_LENGTH-1:BTB_IW+2];
    w_pht_new   = w_pred_upd;
    if (w_actual) begin
      if (w_pred_upd != 2'b11) w_pht_new = w_pred_upd + 2'd1;
    end else begin
      if (w_pred_upd != 2'b00) w_pht_new = w_pred_upd - 2'd1;
    end
  end

  // Updates are held off for the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_upd_en <= 1'b0;
    else        r_upd_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LHT_ENTRIES; i++) r_lht[i] <= '0;
      for (int unsigned i = 0; i < PHT_N; i++)       r_pht[i] <= 2'b01;
      r_btb_vld <= '0;
    end else if (w_upd) begin
      r_lht[w_u_lht_idx] <= {w_lbhr_old[L-2:0], w_actual};
      r_pht[w_lbhr_old]  <= w_pht_new;
      if (w_actual) r_btb_vld[w_u_btb_idx] <= 1'b1;
    end
  end

  // Tag/target storage is qualified by the valid bits, so it needs no reset
  always_ff @(posedge clk) begin
    if (w_upd && w_actual) begin
      r_btb_tag[w_u_btb_idx] <= w_u_tag;
      r_btb_tgt[w_u_btb_idx] <= update_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else if (w_upd) begin
      if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + 32'd1;
      if (w_wrong && (r_mispredict_cnt != '1))
        r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
    end
  end

  assign branch_cnt     = r_branch_cnt;
  assign mispredict_cnt = r_mispredict_cnt;

endmodule

// File: doc/rvs192_local_bp.md
# rvs192_local_bp

Local-history branch predictor for the RVS192 fetch stage, built for the `LOCAL_BP` configuration. It sits directly upstream of the fetch/decode pipeline register. Each cycle it looks up the fetch PC and produces the `br_check_type` fields (`LBP_predict`, `LBHR`, `branch_take`) plus a predicted next PC. It is trained from the execute stage through the `br_update_type` fields. The block holds:
- a per-PC local history table (LHT);
- a history-indexed pattern history table (PHT) of 2-bit counters;
- a direct-mapped branch target buffer (BTB);
- two saturating performance counters.

## Interface
Parameters:
- `PC_LENGTH`, 32, PC width.
- `LOCAL_HISTORY_LENGTH`, 4, LHT entry width (L); PHT has 2^L entries.
- `LHT_ENTRIES`, 64, LHT depth, power of two.
- `BTB_ENTRIES`, 16, BTB depth, power of two.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fetch_pc`  in  PC_LENGTH  PC being fetched this cycle.
- `br_check`  out  2+L+1  packed {`LBP_predict`[1:0], `LBHR`[L-1:0], `branch_take`}.
- `pred_pc`  out  PC_LENGTH  predicted next fetch PC.
- `br_update`  in  2+L+3  packed {`LBP_predict_update`[1:0], `LBHR_old`[L-1:0], `update`, `wrong`, `actual`}.
- `update_pc`  in  PC_LENGTH  PC of the resolved branch.
- `update_target`  in  PC_LENGTH  computed taken target of the resolved branch.
- `branch_cnt`  out  32  resolved-branch count.
- `mispredict_cnt`  out  32  misprediction count.

## Operation
- Index fields:
  - LHT index = pc[log2(LHT_ENTRIES)+1:2].
  - BTB index = pc[log2(BTB_ENTRIES)+1:2].
  - BTB tag = pc[PC_LENGTH-1:log2(BTB_ENTRIES)+2].
- Lookup is purely combinational from `fetch_pc` and the current state:
  - `LBHR` = LHT[lht_idx(fetch_pc)].
  - `LBP_predict` = PHT[`LBHR`].
  - `btb_hit` = valid[bi] && tag[bi] == tag(fetch_pc).
  - `branch_take` = `btb_hit` && `LBP_predict`[1].
  - `pred_pc` = `branch_take` ? target[bi] : `fetch_pc` + 4. The addition is modulo 2^PC_LENGTH.
- Training applies only when `update`=1, and all writes occur on the rising edge:
  - LHT[lht_idx(update_pc)] <= {`LBHR_old`[L-2:0], `actual`}. The shift discards the MSB and inserts `actual` at the LSB.
  - PHT[`LBHR_old`] <= sat(`LBP_predict_update`, `actual`). The base value is the counter captured at prediction time, not the current PHT contents.
  - Counter update: +1 when taken, -1 when not taken, clamped to the range 00..11.
  - If `actual`=1, the BTB entry for `update_pc` is overwritten: valid=1, tag, target=`update_target`.
  - If `actual`=0, the BTB is untouched.
- Performance counters:
  - `branch_cnt` increments on `update`.
  - `mispredict_cnt` increments on `update`&&`wrong`.
  - Both saturate at 0xFFFF_FFFF.
- When `update`=0, all other `br_update` fields, `update_pc` and `update_target` are ignored.

## Timing
- Lookup latency is 0 cycles (combinational). Update latency is 1 cycle: the write is visible to a lookup starting in the cycle after the `update` edge.
- Same-cycle update and lookup of the same entry: the lookup returns the pre-update value. There is no write-through bypass.
- Back-to-back updates to the same entry in consecutive cycles are both applied in order; the last one wins.
- There is no handshake. `update` is a single-cycle qualifier and the block never stalls.
- Reset (`rst_n`=0) takes effect immediately, asynchronously, including mid-operation:
  - all LHT entries = 0;
  - all PHT entries = 2'b01 (weakly not taken);
  - all BTB valid bits = 0;
  - both counters = 0.
- Output values while in reset: `br_check` = {01, 0, 0}; `pred_pc` = `fetch_pc`+4; `branch_cnt` = `mispredict_cnt` = 0.
- An update presented in the same edge as reset release is ignored.

## Test plan
- **Reset defaults:** hold reset, then drive `fetch_pc`=0x100 → `LBP_predict`=01, `LBHR`=0000, `branch_take`=0, `pred_pc`=0x104, both counters 0.
- **Training to taken:**
  - Stimulus: five updates at `update_pc`=0x100, `update_target`=0x80, `actual`=1, `LBP_predict_update`=01, with `LBHR_old` = 0000, 0001, 0011, 0111, 1111 in turn.
  - Response: LHT entry = 1111, PHT[1111] = 10; lookup of 0x100 → `branch_take`=1, `pred_pc`=0x80, `branch_cnt`=5.
- **Counter saturation:**
  - Update with `LBP_predict_update`=11, `actual`=1 → PHT entry stays 11.
  - Update with `LBP_predict_update`=00, `actual`=0 → PHT entry stays 00.
  - Update with `actual`=0 at a BTB-hit PC → BTB entry unchanged.
- **BTB alias:**
  - Train 0x100 taken to 0x80, with PHT[`LBHR`] ≥ 10.
  - Look up 0x140 (same index, different tag) with the same history → `branch_take`=0, `pred_pc`=0x144.
- **Same-cycle update/lookup:** look up 0x100 in the same cycle as its first taken update → pre-update outputs (`LBHR`=0000, take 0); the next cycle shows `LBHR`=0001.
- **Mispredict count and async reset mid-run:**
  - Three updates with `wrong`=1 → `mispredict_cnt`=3.
  - Drop `rst_n` between clock edges → counters read 0 immediately, and predictions return to reset defaults.
